// File: rtl/cam_pwr_seq.sv
// Camera power sequencer: orders PWDN, XCLK enable and RESETB from one level power request.
// Optional `CAM_PWR_SEQ_STATUS_EN exposes the registered FSM state on seq_state.
module cam_pwr_seq #(
    parameter int unsigned T_PWDN_CYC = 16,
    parameter int unsigned T_XCLK_CYC = 64,
    parameter int unsigned T_BOOT_CYC = 256,
    parameter int unsigned T_RST_CYC  = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwr_req,
    output logic       xclk_en,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       ready,
    output logic       busy
`ifdef CAM_PWR_SEQ_STATUS_EN
    ,
    output logic [2:0] seq_state
`endif
);

    typedef enum logic [2:0] {
        StOff    = 3'd0,
        StUpPwdn = 3'd1,
        StUpXclk = 3'd2,
        StUpBoot = 3'd3,
        StOn     = 3'd4,
        StDnRst  = 3'd5,
        StDnXclk = 3'd6,
        StDnPwdn = 3'd7
    } state_e;

    // Counters are loaded with T-1 so each timed state lasts exactly T cycles.
    localparam logic [CNT_WIDTH-1:0] PwdnLoad = CNT_WIDTH'(T_PWDN_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] XclkLoad = CNT_WIDTH'(T_XCLK_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] BootLoad = CNT_WIDTH'(T_BOOT_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] RstLoad  = CNT_WIDTH'(T_RST_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 cnt_done;

    assign cnt_done = (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StOff;
            cnt_q     <= '0;
            xclk_en   <= 1'b0;
            cam_pwdn  <= 1'b1;
            cam_rst_n <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                StOff: begin
                    if (pwr_req) begin
                        state_q  <= StUpPwdn;
                        cnt_q    <= PwdnLoad;
                        cam_pwdn <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                StUpPwdn, StUpXclk, StUpBoot: begin
                    // Abort wins over a same-cycle dwell expiry; pins other than RESETB hold.
                    if (!pwr_req) begin
                        state_q   <= StDnRst;
                        cnt_q     <= RstLoad;
                        cam_rst_n <= 1'b0;
                    end else if (cnt_done) begin
                        if (state_q == StUpPwdn) begin
                            state_q <= StUpXclk;
                            cnt_q   <= XclkLoad;
                            xclk_en <= 1'b1;
                        end else if (state_q == StUpXclk) begin
                            state_q   <= StUpBoot;
                            cnt_q     <= BootLoad;
                            cam_rst_n <= 1'b1;
                        end else begin
                            state_q <= StOn;
                            ready   <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StOn: begin
                    if (!pwr_req) begin
                        state_q   <= StDnRst;
                        cnt_q     <= RstLoad;
                        cam_rst_n <= 1'b0;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                StDnRst, StDnXclk, StDnPwdn: begin
                    if (cnt_done) begin
                        if (state_q == StDnRst) begin
                            state_q <= StDnXclk;
                            cnt_q   <= XclkLoad;
                            xclk_en <= 1'b0;
                        end else if (state_q == StDnXclk) begin
                            state_q  <= StDnPwdn;
                            cnt_q    <= PwdnLoad;
                            cam_pwdn <= 1'b1;
                        end else begin
                            state_q <= StOff;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                default: state_q <= StOff;
            endcase
        end
    end

`ifdef CAM_PWR_SEQ_STATUS_EN
    assign seq_state = state_q;
`endif

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Self-checking bench for cam_pwr_seq: directed milestone checks plus randomized
// pwr_req/reset traffic compared against an elapsed-time reference model.
module tb_cam_pwr_seq;

    localparam int TP     = 4;
    localparam int TX     = 8;
    localparam int TB     = 16;
    localparam int TR     = 2;
    localparam int UP_TOT = TP + TX + TB;
    localparam int DN_TOT = TR + TX + TP;

    localparam logic [1:0] M_OFF = 2'd0;
    localparam logic [1:0] M_UP  = 2'd1;
    localparam logic [1:0] M_ON  = 2'd2;
    localparam logic [1:0] M_DN  = 2'd3;

    logic       clk;
    logic       rst;
    logic       pwr_req;
    logic       xclk_en;
    logic       cam_pwdn;
    logic       cam_rst_n;
    logic       ready;
    logic       busy;
`ifdef CAM_PWR_SEQ_STATUS_EN
    logic [2:0] seq_state;
`endif
    logic [4:0] outs;

    int checks;
    int failures;

    cam_pwr_seq #(
        .T_PWDN_CYC(TP),
        .T_XCLK_CYC(TX),
        .T_BOOT_CYC(TB),
        .T_RST_CYC (TR),
        .CNT_WIDTH (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pwr_req  (pwr_req),
        .xclk_en  (xclk_en),
        .cam_pwdn (cam_pwdn),
        .cam_rst_n(cam_rst_n),
        .ready    (ready),
        .busy     (busy)
`ifdef CAM_PWR_SEQ_STATUS_EN
        ,
        .seq_state(seq_state)
`endif
    );

    assign outs = {xclk_en, cam_pwdn, cam_rst_n, ready, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks elapsed cycles since a sequence began, not per-state dwell.
    logic [1:0] m_mode;
    int         m_t;
    int         m_d;
    logic       m_x0;
    logic       m_p0;
    logic [4:0] exp_outs;
    logic [2:0] exp_state;

    always_comb begin
        exp_outs  = 5'b01000;
        exp_state = 3'd0;
        case (m_mode)
            M_UP: begin
                exp_outs  = {(m_t >= TP), 1'b0, (m_t >= TP + TX), 1'b0, 1'b1};
                exp_state = (m_t < TP) ? 3'd1 : ((m_t < TP + TX) ? 3'd2 : 3'd3);
            end
            M_ON: begin
                exp_outs  = 5'b10110;
                exp_state = 3'd4;
            end
            M_DN: begin
                exp_outs  = {((m_d < TR) ? m_x0 : 1'b0), ((m_d < TR + TX) ? m_p0 : 1'b1),
                             1'b0, 1'b0, 1'b1};
                exp_state = (m_d < TR) ? 3'd5 : ((m_d < TR + TX) ? 3'd6 : 3'd7);
            end
            default: ;
        endcase
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= M_OFF;
            m_t    <= 0;
            m_d    <= 0;
            m_x0   <= 1'b0;
            m_p0   <= 1'b1;
        end else begin
            case (m_mode)
                M_OFF: if (pwr_req) begin
                    m_mode <= M_UP;
                    m_t    <= 0;
                end
                M_UP: begin
                    if (!pwr_req) begin
                        m_mode <= M_DN;
                        m_d    <= 0;
                        m_x0   <= exp_outs[4];
                        m_p0   <= exp_outs[3];
                    end else begin
                        if (m_t + 1 == UP_TOT) m_mode <= M_ON;
                        m_t <= m_t + 1;
                    end
                end
                M_ON: if (!pwr_req) begin
                    m_mode <= M_DN;
                    m_d    <= 0;
                    m_x0   <= 1'b1;
                    m_p0   <= 1'b0;
                end
                default: begin
                    if (m_d + 1 == DN_TOT) m_mode <= M_OFF;
                    m_d <= m_d + 1;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        if (outs !== 5'b01000) begin
            failures++;
            $display("FAIL reset_held outs=%b expected=%b", outs, 5'b01000);
        end
        checks++;
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (outs !== 5'b01000) begin
                failures++;
                $display("FAIL reset_idle k=%0d outs=%b expected=%b", k, outs, 5'b01000);
            end
            checks++;
        end
    endtask

    task automatic test_power_up();
        logic [4:0] exp;
        pwr_req = 1'b1;
        for (int k = 0; k <= UP_TOT; k++) begin
            tick();
            exp = {(k >= TP), 1'b0, (k >= TP + TX), (k >= UP_TOT), (k < UP_TOT)};
            if (outs !== exp) begin
                failures++;
                $display("FAIL power_up E+%0d outs=%b expected=%b", k, outs, exp);
            end
            checks++;
        end
    endtask

    task automatic test_power_down();
        logic [4:0] exp;
        pwr_req = 1'b0;
        for (int k = 0; k <= DN_TOT + 1; k++) begin
            tick();
            exp = {(k < TR), (k >= TR + TX), 1'b0, 1'b0, (k < DN_TOT)};
            if (outs !== exp) begin
                failures++;
                $display("FAIL power_down F+%0d outs=%b expected=%b", k, outs, exp);
            end
            checks++;
        end
    endtask

    task automatic test_abort();
        logic [4:0] exp;
        pwr_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp = {(k >= TP), 1'b0, 1'b0, 1'b0, 1'b1};
            if (outs !== exp) begin
                failures++;
                $display("FAIL abort_up E+%0d outs=%b expected=%b", k, outs, exp);
            end
            checks++;
        end
        pwr_req = 1'b0;
        for (int j = 0; j <= DN_TOT + 1; j++) begin
            tick();
            exp = {(j < TR), (j >= TR + TX), 1'b0, 1'b0, (j < DN_TOT)};
            if (outs !== exp) begin
                failures++;
                $display("FAIL abort_down A+%0d outs=%b expected=%b", j, outs, exp);
            end
            checks++;
        end
    endtask

    task automatic test_rerequest();
        logic [4:0] exp;
        int         u;
        pwr_req = 1'b1;
        repeat (UP_TOT + 1) tick();
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL rereq_on ready=%b expected=1", ready);
        end
        checks++;
        pwr_req = 1'b0;
        for (int k = 0; k <= DN_TOT + 2; k++) begin
            if (k == 4) pwr_req = 1'b1;
            tick();
            u   = k - DN_TOT - 1;
            exp = (k < DN_TOT)  ? {(k < TR), (k >= TR + TX), 1'b0, 1'b0, 1'b1} :
                  (k == DN_TOT) ? 5'b01000 :
                                  {(u >= TP), 1'b0, (u >= TP + TX), 1'b0, 1'b1};
            if (outs !== exp) begin
                failures++;
                $display("FAIL rerequest F+%0d outs=%b expected=%b", k, outs, exp);
            end
            checks++;
        end
    endtask

    // Continues from test_rerequest: the up sequence restarted one cycle ago.
    task automatic test_async_reset();
        repeat (13) tick();
        if (outs !== 5'b10101) begin
            failures++;
            $display("FAIL arst_boot outs=%b expected=%b", outs, 5'b10101);
        end
        checks++;
        #2;
        rst     = 1'b1;
        pwr_req = 1'b0;
        #1;
        if (outs !== 5'b01000) begin
            failures++;
            $display("FAIL arst_immediate outs=%b expected=%b", outs, 5'b01000);
        end
        checks++;
`ifdef CAM_PWR_SEQ_STATUS_EN
        if (seq_state !== 3'd0) begin
            failures++;
            $display("FAIL arst_state seq_state=%0d expected=0", seq_state);
        end
        checks++;
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();
        if (outs !== 5'b01000) begin
            failures++;
            $display("FAIL arst_after outs=%b expected=%b", outs, 5'b01000);
        end
        checks++;
    endtask

    task automatic test_random();
        int run;
        run = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run == 0) begin
                pwr_req = 1'($urandom_range(0, 1));
                run     = $urandom_range(1, 45);
            end
            run--;
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
            if (outs !== exp_outs) begin
                failures++;
                $display("FAIL random c=%0d outs=%b expected=%b", c, outs, exp_outs);
            end
            checks++;
`ifdef CAM_PWR_SEQ_STATUS_EN
            if (seq_state !== exp_state) begin
                failures++;
                $display("FAIL random_state c=%0d state=%0d expected=%0d", c, seq_state,
                         exp_state);
            end
            checks++;
`endif
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        pwr_req  = 1'b0;
        @(negedge clk);
        test_reset();
        test_power_up();
        test_power_down();
        test_abort();
        test_rerequest();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
